// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: word/byte geometry and FSM state encoding.
package imem_loader_pkg;

  localparam int INSTR_WIDTH     = 32;
  localparam int BYTE_WIDTH      = 8;
  localparam int BYTES_PER_WORD  = INSTR_WIDTH / BYTE_WIDTH;
  localparam int BYTE_IDX_W      = $clog2(BYTES_PER_WORD);
  localparam int IMEM_ADDR_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream link from the host: the host drives data/valid, the loader answers with ready.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic [BYTE_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes big-endian into one instruction word; first byte lands in the MSBs.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   beat,
  input  logic [BYTE_WIDTH-1:0]  rx_byte,
  output logic [INSTR_WIDTH-1:0] word,
  output logic                   word_full
);

  localparam int SHIFT_W = INSTR_WIDTH - BYTE_WIDTH;

  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;

  // word is the completed value on the beat that fills it, so no extra cycle is spent assembling
  always_comb begin
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    word       = {shift_q, rx_byte};
    word_full  = beat && (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));
    if (clear) begin
      byte_idx_d = '0;
    end else if (beat) begin
      byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
      shift_d    = word[SHIFT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
    end
  end

  // Partial bytes are discarded by zeroing the index, so the shift register itself needs no reset
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams bytes from the host into imem, holding the core in reset
// until the requested number of words has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH:0]    word_count,
  imem_loader_if.slave           rx,
  output logic                   imem_we,
  output logic [INSTR_WIDTH-1:0] imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   cpu_reset,
  output logic                   busy,
  output logic                   done,
  output logic [BYTE_WIDTH-1:0]  checksum
);

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  function automatic logic [ADDR_WIDTH:0] clamp_count(input logic [ADDR_WIDTH:0] n);
    return (n > MAX_WORDS) ? MAX_WORDS : n;
  endfunction

  function automatic logic [BYTE_WIDTH-1:0] csum_add(input logic [BYTE_WIDTH-1:0] a,
                                                     input logic [BYTE_WIDTH-1:0] b);
    return a + b;
  endfunction

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH:0]    n_q, n_d;
  logic [ADDR_WIDTH-1:0]  word_idx_q, word_idx_d;
  logic [BYTE_WIDTH-1:0]  checksum_q, checksum_d;
  logic                   imem_we_q, imem_we_d;
  logic [INSTR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [INSTR_WIDTH-1:0] imem_wdata_q, imem_wdata_d;

  logic                   rx_ready;
  logic                   beat;
  logic                   pack_clear;
  logic [INSTR_WIDTH-1:0] packed_word;
  logic                   word_full;
  logic                   last_word;
  logic [ADDR_WIDTH:0]    start_count;

  assign rx_ready    = (state_q == LOAD);
  assign beat        = rx.rx_valid && rx_ready;
  assign rx.rx_ready = rx_ready;
  assign start_count = clamp_count(word_count);
  assign last_word   = (({1'b0, word_idx_q} + {{ADDR_WIDTH{1'b0}}, 1'b1}) == n_q);

  imem_loader_byte_packer u_packer (
    .clk       (clk),
    .rst       (reset),
    .clear     (pack_clear),
    .beat      (beat),
    .rx_byte   (rx.rx_data),
    .word      (packed_word),
    .word_full (word_full)
  );

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    word_idx_d   = word_idx_q;
    checksum_d   = checksum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    pack_clear   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          n_d        = start_count;
          word_idx_d = '0;
          checksum_d = '0;
          pack_clear = 1'b1;
          state_d    = (start_count == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (beat) begin
          checksum_d = csum_add(checksum_q, rx.rx_data);
        end
        // The write strobe is registered here so it lands exactly in the WRITE cycle
        if (word_full) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = INSTR_WIDTH'({word_idx_q, {BYTE_IDX_W{1'b0}}});
          imem_wdata_d = packed_word;
          state_d      = WRITE;
        end
      end
      WRITE: begin
        // Index stops on the final word so it never wraps past the top of memory
        if (last_word) begin
          state_d = DONE;
        end else begin
          word_idx_d = word_idx_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          state_d    = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      n_q          <= '0;
      word_idx_q   <= '0;
      checksum_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      word_idx_q   <= word_idx_d;
      checksum_q   <= checksum_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign checksum   = checksum_q;
  assign cpu_reset  = (state_q != DONE);
  assign busy       = (state_q == LOAD) || (state_q == WRITE);
  assign done       = (state_q == DONE);

  a_core_vs_done : assert property (@(posedge clk) disable iff (reset) !(cpu_reset && done));
  a_busy_vs_done : assert property (@(posedge clk) disable iff (reset) !(busy && done));
  a_we_one_cycle : assert property (@(posedge clk) disable iff (reset) imem_we |=> !imem_we);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of loads plus hand-written reset/abort sequences.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] word_count;
  logic       imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic [7:0] checksum;

  imem_loader_if rx_if();

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .rx         (rx_if),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          wc;
    bit          toggle;
    int          pat;
    bit          mid_start;
    int          exp_words;
    logic [31:0] exp_last_addr;
    int          exp_csum;   // -1: use the bench's running byte sum
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          we_cnt = 0;
  logic [31:0] last_addr = '0;
  logic        prev_we = 1'b0;
  vec_t        vecs[6];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat_byte(input int p, input int idx);
    logic [7:0] spec_bytes [8];
    spec_bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    if (p == 0) return spec_bytes[idx % 8];
    return 8'((idx * 37 + 11) & 255);
  endfunction

  // Scoreboard / invariant monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      chk1("inv_cpu_reset_and_done", cpu_reset && done, 1'b0);
      chk1("inv_busy_and_done", busy && done, 1'b0);
    end
    if (imem_we) begin
      chk1("we_single_cycle", prev_we, 1'b0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_we: got write addr 0x%08h data 0x%08h, want none", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk32("write_addr", imem_addr, e.addr);
        chk32("write_data", imem_wdata, e.data);
      end
      we_cnt++;
      last_addr = imem_addr;
    end
    prev_we = imem_we;
  end

  // Hold one byte until the loader takes it; returns aligned at posedge+1
  task automatic send_byte(input logic [7:0] b);
    bit hs;
    int n;
    hs = 1'b0;
    n  = 0;
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    while (!hs && n < 16) begin
      @(negedge clk);
      hs = rx_if.rx_ready;
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    rx_if.rx_valid = 1'b0;
    if (!hs) begin
      n_cmp++;
      n_fail++;
      $display("FAIL handshake_timeout: got no rx_ready in 16 cycles, want byte 0x%02h accepted", b);
    end
  endtask

  task automatic pulse_start(input int wc);
    @(posedge clk);
    #1;
    start      = 1'b1;
    word_count = 8'(wc);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_load(input vec_t v);
    logic [7:0]  b;
    logic [7:0]  sum;
    logic [31:0] word;
    int          i;
    sum    = '0;
    we_cnt = 0;
    pulse_start(v.wc);
    @(negedge clk);
    if (v.exp_words == 0) begin
      chk1("zero_count_done_next_cycle", done, 1'b1);
    end else begin
      chk1("start_cpu_reset", cpu_reset, 1'b1);
      chk1("start_busy", busy, 1'b1);
      chk1("start_rx_ready", rx_if.rx_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    for (int w = 0; w < v.exp_words; w++) begin
      word = '0;
      for (int k = 0; k < 4; k++) begin
        b    = pat_byte(v.pat, w * 4 + k);
        sum  = sum + b;
        word = {word[23:0], b};
        if (v.mid_start && w == 0 && k == 2) begin
          start      = 1'b1;
          word_count = 8'd1;
        end
        send_byte(b);
        if (k == 3) exp_q.push_back('{addr: 32'(w * 4), data: word});
        if (v.toggle) begin
          @(posedge clk);
          #1;
        end
      end
    end
    i = 0;
    while (!done && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk1("load_done", done, 1'b1);
    chk1("done_cpu_reset", cpu_reset, 1'b0);
    chk1("done_busy", busy, 1'b0);
    chk1("done_rx_ready", rx_if.rx_ready, 1'b0);
    chk32("checksum", 32'(checksum), (v.exp_csum >= 0) ? 32'(v.exp_csum) : 32'(sum));
    chk32("write_count", 32'(we_cnt), 32'(v.exp_words));
    chk32("writes_outstanding", 32'(exp_q.size()), 32'd0);
    if (v.exp_words > 0) begin
      chk32("last_write_addr", last_addr, v.exp_last_addr);
      chk32("addr_holds_after_write", imem_addr, v.exp_last_addr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish by 500us, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  b;
    logic [31:0] word;
    vec_t        rec;

    vecs[0] = '{wc: 2,   toggle: 0, pat: 0, mid_start: 0, exp_words: 2,   exp_last_addr: 32'h4,   exp_csum: 8'hC6};
    vecs[1] = '{wc: 2,   toggle: 1, pat: 0, mid_start: 0, exp_words: 2,   exp_last_addr: 32'h4,   exp_csum: 8'hC6};
    vecs[2] = '{wc: 0,   toggle: 0, pat: 0, mid_start: 0, exp_words: 0,   exp_last_addr: 32'h0,   exp_csum: 0};
    vecs[3] = '{wc: 1,   toggle: 0, pat: 1, mid_start: 0, exp_words: 1,   exp_last_addr: 32'h0,   exp_csum: -1};
    vecs[4] = '{wc: 2,   toggle: 0, pat: 0, mid_start: 1, exp_words: 2,   exp_last_addr: 32'h4,   exp_csum: 8'hC6};
    vecs[5] = '{wc: 200, toggle: 0, pat: 1, mid_start: 0, exp_words: 128, exp_last_addr: 32'h1FC, exp_csum: -1};

    reset          = 1'b1;
    start          = 1'b0;
    word_count     = '0;
    rx_if.rx_data  = '0;
    rx_if.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_rx_ready", rx_if.rx_ready, 1'b0);
    chk1("rst_imem_we", imem_we, 1'b0);
    chk32("rst_imem_addr", imem_addr, 32'h0);
    chk32("rst_imem_wdata", imem_wdata, 32'h0);
    chk1("rst_cpu_reset", cpu_reset, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk32("rst_checksum", 32'(checksum), 32'h0);

    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk1("idle_cpu_reset", cpu_reset, 1'b1);
    chk1("idle_rx_ready", rx_if.rx_ready, 1'b0);
    chk1("idle_done", done, 1'b0);
    chk32("idle_no_writes", 32'(we_cnt), 32'd0);
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) run_load(vecs[v]);

    // Reset after two bytes of word 1: word 0 stays written, partial word is dropped
    we_cnt = 0;
    pulse_start(2);
    @(negedge clk);
    @(posedge clk);
    #1;
    word = '0;
    for (int k = 0; k < 6; k++) begin
      b    = pat_byte(1, k);
      word = {word[23:0], b};
      send_byte(b);
      if (k == 3) exp_q.push_back('{addr: 32'h0, data: word});
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("midrst_cpu_reset", cpu_reset, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk32("midrst_checksum", 32'(checksum), 32'h0);
    chk32("midrst_imem_addr", imem_addr, 32'h0);
    chk32("midrst_imem_wdata", imem_wdata, 32'h0);
    rx_if.rx_data  = 8'hAA;
    rx_if.rx_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk1("midrst_idle_rx_ready", rx_if.rx_ready, 1'b0);
    end
    rx_if.rx_valid = 1'b0;
    chk32("midrst_only_word0", 32'(we_cnt), 32'd1);
    chk32("midrst_outstanding", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Load again straight from IDLE after the aborted one
    rec = '{wc: 3, toggle: 1, pat: 1, mid_start: 0, exp_words: 3, exp_last_addr: 32'h8, exp_csum: -1};
    run_load(rec);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
